branch_resolve_unit: RTL
========================

# branch_resolve_unit

Execute-stage branch resolver for the pipelined 64-bit processor. Consumes the ALU result flags, with Z taken from the 64-bit zero detector's `zero_flag`. Holds the architectural NZCV flag register, evaluates B, CBZ, CBNZ and B.cond for the instruction in EX, and issues a registered one-cycle PC redirect plus front-end flush on a taken branch. Fetch always predicts not-taken, so every taken branch is a redirect.

## Interface
- `ADDR_W`, 64, width of branch target and redirect PC
- `clk`  in  1  pipeline clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  EX holds a real (non-bubble) instruction
- `ex_set_flags`  in  1  instruction writes NZCV (ADDS/SUBS/ANDS)
- `ex_br_type`  in  3  branch type: NONE=0, B=1, CBZ=2, CBNZ=3, BCOND=4; 5–7 treated as NONE
- `ex_cond`  in  4  B.cond condition code, standard ARM encoding
- `ex_br_target`  in  ADDR_W  computed branch target
- `zero_flag`  in  1  Z of current ALU result; for CBZ/CBNZ the ALU passes Rt through
- `alu_neg`, `alu_carry`, `alu_ovf`  in  1 each  N, C, V of current ALU result
- `stall`  in  1  pipeline hold; no state update while high
- `flags_q`  out  4  architectural {N,Z,C,V}
- `redirect`  out  1  load `redirect_pc` into PC
- `redirect_pc`  out  ADDR_W  taken-branch target
- `flush`  out  1  squash IF/ID and ID/EX contents

## Operation
- State machine, 2 states: RUN, REDIRECT.
- Instruction is *accepted* when `ex_valid & ~stall & state==RUN`. In REDIRECT the EX instruction is wrong-path: it is ignored, so it sets no flags and resolves no branch.
- Flag update on accept with `ex_set_flags`: `flags_q <= {alu_neg, zero_flag, alu_carry, alu_ovf}`.
- Taken condition on accept:
  - B: always taken.
  - CBZ: taken when `zero_flag`.
  - CBNZ: taken when `~zero_flag`.
  - BCOND: taken when `cond_eval(ex_cond, flags_q)` is true. It uses the registered flags, never the current ALU flags.
- `cond_eval` truth, by code:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E, F: always true.
- Branch type NONE with `ex_set_flags` updates flags only. A branch with `ex_set_flags` is illegal; flags are still written, but B.cond uses pre-update flags.
- Transitions:
  - RUN → REDIRECT on accepted taken branch; `redirect_pc` captures `ex_br_target`.
  - REDIRECT → RUN on the first cycle with `stall` low.
  - REDIRECT with `stall` high: stay in REDIRECT, keep asserting outputs.
- `redirect = flush = (state==REDIRECT)`.
- Reset, asynchronous: state=RUN, `flags_q`=0, `redirect_pc`=0, `redirect`=0, `flush`=0. Reset mid-REDIRECT drops `redirect` immediately; no pending redirect survives.

## Timing
- Flag latency: updated flags are visible on `flags_q` one cycle after accept. B.cond directly after ADDS sees the new flags, with no bypass.
- Branch latency: taken branch accepted at edge N; `redirect`/`flush` high during cycle N+1. Minimum one wrong-path instruction is squashed.
- Back-to-back taken branches: the second is in the REDIRECT shadow, is therefore ignored and never redirects.
- `stall` freezes state, `flags_q` and `redirect_pc` unconditionally.

## Configuration
- `BR_STATS_EN` defined:
  - Adds outputs `br_count[31:0]` (accepted branches, any taken/not-taken outcome) and `br_taken_count[31:0]`.
  - Counters are reset to 0, increment on accept, wrap at 2^32.
  - Ignored/squashed instructions do not count.
- `BR_STATS_EN` undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package `proc_pkg` holds:
  - `br_type_e` (3-bit enum).
  - `cond_e` (4-bit enum, EQ..NV).
  - `flags_t` (packed struct n,z,c,v).
  - `ADDR_W` default constant.
- Sub-module `cond_eval`: combinational, inputs `cond_e` and `flags_t`, output `taken`. Reusable by any future early-branch logic.

## Test plan
- Reset, then ADDS with N=0 Z=1 C=1 V=0 accepted → next cycle `flags_q`=4'b0110, `redirect`=0.
- Next cycle B.EQ, target 0x400 → following cycle `redirect`=1, `flush`=1, `redirect_pc`=0x400 for exactly one cycle.
- CBNZ with `zero_flag`=1, then CBZ with `zero_flag`=1, target 0x80 → first: no redirect; second: redirect to 0x80.
- Taken B to 0x100, then SUBS and B to 0x200 in the shadow cycle → only 0x100 redirect; `flags_q` unchanged by the shadow SUBS.
- Taken branch, then `stall` high 3 cycles during REDIRECT → `redirect` held 4 cycles total. Separately, `reset_n` low mid-REDIRECT → `redirect`=0 immediately and `flags_q`=0.
- With `BR_STATS_EN`: 3 branches accepted, 2 taken, 1 squashed → `br_count`=3, `br_taken_count`=2.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor types: branch types, ARM condition codes, NZCV flags and
// the default address width used by the execute-stage branch resolver.
package proc_pkg;

    localparam int PROC_ADDR_W = 64;

    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_B     = 3'd1,
        BR_CBZ   = 3'd2,
        BR_CBNZ  = 3'd3,
        BR_BCOND = 3'd4
    } br_type_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_HS = 4'h2,
        COND_LO = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } bru_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against an NZCV flag set.
// Shared by the EX branch resolver and any future early-branch logic.
module cond_eval
    import proc_pkg::*;
(
    input  cond_e  cond,
    input  flags_t flags,
    output logic   taken
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = flags.z;
            COND_NE: taken = ~flags.z;
            COND_HS: taken = flags.c;
            COND_LO: taken = ~flags.c;
            COND_MI: taken = flags.n;
            COND_PL: taken = ~flags.n;
            COND_VS: taken = flags.v;
            COND_VC: taken = ~flags.v;
            COND_HI: taken = flags.c & ~flags.z;
            COND_LS: taken = ~flags.c | flags.z;
            COND_GE: taken = (flags.n == flags.v);
            COND_LT: taken = (flags.n != flags.v);
            COND_GT: taken = ~flags.z & (flags.n == flags.v);
            COND_LE: taken = flags.z | (flags.n != flags.v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: NZCV register, branch evaluation, and a
// registered one-cycle redirect/flush. Optional counters under BR_STATS_EN.
module branch_resolve_unit
    import proc_pkg::*;
#(
    parameter int ADDR_W = PROC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic [2:0]        ex_br_type,
    input  logic [3:0]        ex_cond,
    input  logic [ADDR_W-1:0] ex_br_target,
    input  logic              zero_flag,
    input  logic              alu_neg,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              stall,
    output logic [3:0]        flags_q,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush
`ifdef BR_STATS_EN
    ,
    output logic [31:0]       br_count,
    output logic [31:0]       br_taken_count
`endif
);

    bru_state_e state, state_next;
    flags_t     flags_r;
    logic       accept;
    logic       is_branch;
    logic       br_taken;
    logic       cond_taken;

    // B.cond always sees the registered flags, so an ADDS in the previous
    // cycle is visible without any bypass from the current ALU result.
    cond_eval u_cond_eval (
        .cond  (cond_e'(ex_cond)),
        .flags (flags_r),
        .taken (cond_taken)
    );

    always_comb begin
        accept     = ex_valid & ~stall & (state == ST_RUN);
        is_branch  = 1'b0;
        br_taken   = 1'b0;
        state_next = state;
        redirect   = (state == ST_REDIRECT);
        flush      = (state == ST_REDIRECT);

        case (ex_br_type)
            BR_B: begin
                is_branch = 1'b1;
                br_taken  = 1'b1;
            end
            BR_CBZ: begin
                is_branch = 1'b1;
                br_taken  = zero_flag;
            end
            BR_CBNZ: begin
                is_branch = 1'b1;
                br_taken  = ~zero_flag;
            end
            BR_BCOND: begin
                is_branch = 1'b1;
                br_taken  = cond_taken;
            end
            default: begin
                is_branch = 1'b0;
                br_taken  = 1'b0;
            end
        endcase

        case (state)
            ST_RUN:      if (accept && br_taken) state_next = ST_REDIRECT;
            ST_REDIRECT: if (!stall)             state_next = ST_RUN;
            default:                             state_next = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            flags_r     <= '0;
            redirect_pc <= '0;
        end else begin
            state <= state_next;
            if (accept && ex_set_flags) begin
                flags_r <= '{n: alu_neg, z: zero_flag, c: alu_carry, v: alu_ovf};
            end
            if (accept && br_taken) begin
                redirect_pc <= ex_br_target;
            end
        end
    end

    assign flags_q = flags_r;

`ifdef BR_STATS_EN
    // Only accepted branches count; REDIRECT-shadow and stalled slots never do.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else if (accept && is_branch) begin
            br_count <= br_count + 32'd1;
            if (br_taken) begin
                br_taken_count <= br_taken_count + 32'd1;
            end
        end
    end
`else
    logic unused_is_branch;
    assign unused_is_branch = is_branch;
`endif

endmodule
